// File: rtl/mem_store_unit_pkg.sv
// mem_store_unit_pkg: shared FSM encodings and default sizes for the store unit
package mem_store_unit_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WR_HI, ST_WR_LO, ST_ERRS} state_e;
  localparam int ADDR_W_DEF    = 16;
  localparam int MEM_DEPTH_DEF = 64;
endpackage

// File: rtl/mem_store_unit.sv
// mem_store_unit: splits 16-bit/8-bit store requests into big-endian byte writes
// Ports: CK/RST sync active-high; REQ_VALID/REQ_READY handshake with REQ_ADDR,
// REQ_DATA, REQ_BYTE; MEM_WE/MEM_ADDR/MEM_WDATA byte write port; BUSY, DONE, ERR status.
module mem_store_unit
  import mem_store_unit_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [15:0]       REQ_DATA,
  input  logic              REQ_BYTE,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [7:0]        MEM_WDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);
  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(MEM_DEPTH - 1);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [15:0]       data_q, data_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              byte_q, byte_d, accept, oob;
  always_comb begin
    accept     = REQ_VALID && state_q == ST_IDLE;
    // a word needs ADDR+1 in range too, so its limit is one below the byte limit
    oob        = REQ_BYTE ? REQ_ADDR > LAST_BYTE : REQ_ADDR >= LAST_BYTE;
    state_d    = state_q == ST_IDLE ? (accept ? (oob ? ST_ERRS : ST_WR_HI) : ST_IDLE)
               : (state_q == ST_WR_HI && !byte_q) ? ST_WR_LO : ST_IDLE;
    addr_d     = accept ? REQ_ADDR : addr_q;
    data_d     = accept ? REQ_DATA : data_q;
    byte_d     = accept ? REQ_BYTE : byte_q;
    // the write port is registered and only moves on a write beat, so it holds otherwise
    mem_addr_d = state_d == ST_WR_HI ? addr_d
               : state_d == ST_WR_LO ? addr_q + ADDR_W'(1) : mem_addr_q;
    wdata_d    = state_d == ST_WR_HI ? (byte_d ? data_d[7:0] : data_d[15:8])
               : state_d == ST_WR_LO ? data_q[7:0] : wdata_q;
  end
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      byte_q     <= 1'b0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      byte_q     <= byte_d;
      mem_addr_q <= mem_addr_d;
      wdata_q    <= wdata_d;
    end
  end
  // RST masks the strobes in its own cycle so an aborted beat never reaches memory
  assign MEM_WE    = (state_q == ST_WR_HI || state_q == ST_WR_LO) && !RST;
  assign DONE      = ((state_q == ST_WR_HI && byte_q) || state_q == ST_WR_LO) && !RST;
  assign ERR       = state_q == ST_ERRS && !RST;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = wdata_q;
  assign BUSY      = state_q != ST_IDLE;
  assign REQ_READY = state_q == ST_IDLE;
endmodule

// File: tb/tb_mem_store_unit.sv
// tb_mem_store_unit: directed checks of mem_store_unit against a byte memory model
module tb_mem_store_unit;
  logic        CK = 1'b0, RST = 1'b1, REQ_VALID = 1'b0, REQ_BYTE = 1'b0;
  logic [15:0] REQ_ADDR = '0, REQ_DATA = '0;
  logic        REQ_READY, MEM_WE, BUSY, DONE, ERR;
  logic [15:0] MEM_ADDR;
  logic [7:0]  MEM_WDATA;
  logic [7:0]  mem [64];
  bit          inited = 1'b0;
  int          we_cnt = 0, done_cnt = 0, err_cnt = 0;
  int          tests = 0, fails = 0;
  int          w0, d0, e0;

  mem_store_unit dut (
    .CK(CK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .REQ_BYTE(REQ_BYTE),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CK = ~CK;

  always @(posedge CK) begin
    if (!inited) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(8'hA0 + i);
      inited <= 1'b1;
    end else if (MEM_WE && MEM_ADDR < 16'd64) mem[MEM_ADDR[5:0]] <= MEM_WDATA;
    we_cnt   <= we_cnt + int'(MEM_WE);
    done_cnt <= done_cnt + int'(DONE);
    err_cnt  <= err_cnt + int'(ERR);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d, input logic b);
    REQ_ADDR = a; REQ_DATA = d; REQ_BYTE = b; REQ_VALID = 1'b1;
    step();
    REQ_VALID = 1'b0;
  endtask

  task automatic snap();
    w0 = we_cnt; d0 = done_cnt; e0 = err_cnt;
  endtask

  initial begin
    step(); step();
    check("rst_ready", 32'(REQ_READY), 1);
    check("rst_we",    32'(MEM_WE), 0);
    check("rst_addr",  32'(MEM_ADDR), 0);
    check("rst_wdata", 32'(MEM_WDATA), 0);
    check("rst_busy",  32'(BUSY), 0);
    check("rst_done",  32'(DONE), 0);
    check("rst_err",   32'(ERR), 0);
    RST = 1'b0;
    step();
    check("idle_ready", 32'(REQ_READY), 1);

    store(16'h0004, 16'hBEEF, 1'b0);
    check("w_n1_we",    32'(MEM_WE), 1);
    check("w_n1_addr",  32'(MEM_ADDR), 32'h4);
    check("w_n1_data",  32'(MEM_WDATA), 32'hBE);
    check("w_n1_done",  32'(DONE), 0);
    check("w_n1_ready", 32'(REQ_READY), 0);
    check("w_n1_busy",  32'(BUSY), 1);
    step();
    check("w_n2_we",    32'(MEM_WE), 1);
    check("w_n2_addr",  32'(MEM_ADDR), 32'h5);
    check("w_n2_data",  32'(MEM_WDATA), 32'hEF);
    check("w_n2_done",  32'(DONE), 1);
    step();
    check("w_n3_ready", 32'(REQ_READY), 1);
    check("w_n3_we",    32'(MEM_WE), 0);
    check("w_n3_done",  32'(DONE), 0);
    check("w_hold_addr", 32'(MEM_ADDR), 32'h5);
    check("w_hold_data", 32'(MEM_WDATA), 32'hEF);
    check("w_mem4", 32'(mem[4]), 32'hBE);
    check("w_mem5", 32'(mem[5]), 32'hEF);
    check("w_fetch", 32'({mem[4], mem[5]}), 32'hBEEF);

    store(16'h0007, 16'h12A5, 1'b1);
    check("b_n1_we",   32'(MEM_WE), 1);
    check("b_n1_addr", 32'(MEM_ADDR), 32'h7);
    check("b_n1_data", 32'(MEM_WDATA), 32'hA5);
    check("b_n1_done", 32'(DONE), 1);
    step();
    check("b_n2_ready", 32'(REQ_READY), 1);
    check("b_n2_we",    32'(MEM_WE), 0);
    check("b_mem7", 32'(mem[7]), 32'hA5);
    check("b_mem6", 32'(mem[6]), 32'hA6);
    check("b_mem8", 32'(mem[8]), 32'hA8);

    snap();
    store(16'h003F, 16'h5566, 1'b0);
    check("e_n1_err",  32'(ERR), 1);
    check("e_n1_we",   32'(MEM_WE), 0);
    check("e_n1_busy", 32'(BUSY), 1);
    step();
    check("e_n2_err",   32'(ERR), 0);
    check("e_n2_ready", 32'(REQ_READY), 1);
    check("e_we_beats", 32'(we_cnt - w0), 0);
    check("e_pulses",   32'(err_cnt - e0), 1);
    check("e_mem63", 32'(mem[63]), 32'hDF);

    store(16'h003E, 16'h1234, 1'b0);
    check("w3e_err", 32'(ERR), 0);
    check("w3e_we",  32'(MEM_WE), 1);
    step(); step();
    check("w3e_mem62", 32'(mem[62]), 32'h12);
    check("w3e_mem63", 32'(mem[63]), 32'h34);

    store(16'h003F, 16'h0077, 1'b1);
    check("b3f_we",   32'(MEM_WE), 1);
    check("b3f_done", 32'(DONE), 1);
    step();
    check("b3f_mem63", 32'(mem[63]), 32'h77);

    store(16'h0040, 16'h0099, 1'b1);
    check("b40_err", 32'(ERR), 1);
    check("b40_we",  32'(MEM_WE), 0);
    step();

    snap();
    REQ_ADDR = 16'h0020; REQ_DATA = 16'h1111; REQ_BYTE = 1'b0; REQ_VALID = 1'b1;
    step();
    REQ_ADDR = 16'h0022; REQ_DATA = 16'h2222;
    check("bb_n1_ready", 32'(REQ_READY), 0);
    step();
    check("bb_n2_addr", 32'(MEM_ADDR), 32'h21);
    step();
    check("bb_n3_ready", 32'(REQ_READY), 1);
    check("bb_n3_we",    32'(MEM_WE), 0);
    step();
    REQ_VALID = 1'b0;
    check("bb_n4_we",   32'(MEM_WE), 1);
    check("bb_n4_addr", 32'(MEM_ADDR), 32'h22);
    check("bb_n4_data", 32'(MEM_WDATA), 32'h22);
    step(); step();
    check("bb_beats", 32'(we_cnt - w0), 4);
    check("bb_dones", 32'(done_cnt - d0), 2);
    check("bb_mem20", 32'(mem[32]), 32'h11);
    check("bb_mem21", 32'(mem[33]), 32'h11);
    check("bb_mem22", 32'(mem[34]), 32'h22);
    check("bb_mem23", 32'(mem[35]), 32'h22);

    snap();
    store(16'h0010, 16'hCAFE, 1'b0);
    check("ab_n1_data", 32'(MEM_WDATA), 32'hCA);
    step();
    check("ab_n2_addr", 32'(MEM_ADDR), 32'h11);
    RST = 1'b1;
    #1;
    check("ab_rst_we",   32'(MEM_WE), 0);
    check("ab_rst_done", 32'(DONE), 0);
    step();
    RST = 1'b0;
    #1;
    check("ab_ready", 32'(REQ_READY), 1);
    check("ab_busy",  32'(BUSY), 0);
    check("ab_dones", 32'(done_cnt - d0), 0);
    check("ab_mem10", 32'(mem[16]), 32'hCA);
    check("ab_mem11", 32'(mem[17]), 32'hB1);

    snap();
    RST = 1'b1; REQ_ADDR = 16'h0030; REQ_DATA = 16'h4242; REQ_BYTE = 1'b0; REQ_VALID = 1'b1;
    step();
    RST = 1'b0; REQ_VALID = 1'b0;
    #1;
    check("rv_busy",  32'(BUSY), 0);
    check("rv_ready", 32'(REQ_READY), 1);
    step(); step();
    check("rv_beats", 32'(we_cnt - w0), 0);
    check("rv_mem30", 32'(mem[48]), 32'hD0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
